// File: rtl/stage_modify_fold_pkg.sv
// stage_modify_fold_pkg: opcode bit indices and one-hot helper shared by the modify stage
package stage_modify_fold_pkg;
   localparam int OPCODE_MSB = 7;
   localparam int OP_INC = 0;
   localparam int OP_DEC = 1;
   localparam int OP_INCDP = 2;
   localparam int OP_DECDP = 3;
   localparam int OP_OUT = 4;
   localparam int OP_IN = 5;
   localparam int OP_LOOP = 6;
   localparam int OP_END = 7;
   typedef logic [OPCODE_MSB:0] opcode_t;
   function automatic opcode_t onehot(input int idx);
      return opcode_t'(1) << idx;
   endfunction
endpackage

// File: rtl/stage_modify_fold_accumulator.sv
// stage_modify_fold_accumulator: run-length accumulator for DP moves and cell updates
module stage_modify_fold_accumulator
   import stage_modify_fold_pkg::*;
#(
   parameter int FOLD = 1,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  opcode_t           op_in,
   input  logic              out_free,
   output logic              occ,
   output logic              take,
   output logic              emit,
   output opcode_t           emit_op,
   output logic [STEP_W-1:0] emit_step
);
   typedef enum logic [1:0] {EMPTY, ACC_DP, ACC_CELL} acc_state_t;
   localparam logic signed [STEP_W:0] LIM = {1'b0, {STEP_W{1'b1}}};
   acc_state_t state, state_nx;
   logic signed [STEP_W:0] delta, delta_nx, unit, mag;
   logic is_dp, is_cell, up, same, room, flush;
   always_comb begin
      is_dp = op_in[OP_INCDP] | op_in[OP_DECDP];
      is_cell = op_in[OP_INC] | op_in[OP_DEC];
      up = op_in[OP_INCDP] | op_in[OP_INC];
      unit = up ? {{STEP_W{1'b0}}, 1'b1} : '1;
      same = (state == ACC_DP && is_dp) || (state == ACC_CELL && is_cell);
      room = up ? delta != LIM : delta != -LIM;
      occ = state != EMPTY;
      take = occ ? (valid && same && room) : (FOLD != 0 && valid && (is_dp || is_cell));
      flush = occ && !take && out_free;
      emit = flush && delta != '0;
      mag = delta[STEP_W] ? -delta : delta;
      emit_step = mag[STEP_W-1:0];
      emit_op = onehot(state == ACC_DP ? (delta[STEP_W] ? OP_DECDP : OP_INCDP)
                                       : (delta[STEP_W] ? OP_DEC : OP_INC));
      state_nx = flush ? EMPTY : (take && !occ) ? (is_dp ? ACC_DP : ACC_CELL) : state;
      delta_nx = flush ? '0 : take ? (occ ? delta + unit : unit) : delta;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         delta <= '0;
      end else begin
         state <= state_nx;
         delta <= delta_nx;
      end
   end
endmodule

// File: rtl/stage_modify_fold.sv
// stage_modify_fold: modify stage folding runs of INC/DEC and INCDP/DECDP into one stepped op
module stage_modify_fold
   import stage_modify_fold_pkg::*;
#(
   parameter int FOLD = 1,
   parameter int STEP_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [OPCODE_MSB:0]   operation_in,
   input  logic                  drdy_in,
   output logic                  ack,
   output logic [OPCODE_MSB:0]   operation,
   output logic                  drdy,
   input  logic                  ack_in,
   output logic [STEP_W-1:0]     step,
   output logic                  dp_ce,
   output logic                  dp_down
);
   logic out_free, occ, take, emit, load;
   opcode_t emit_op;
   logic [STEP_W-1:0] emit_step;
   stage_modify_fold_accumulator #(.FOLD(FOLD), .STEP_W(STEP_W)) u_acc (
      .clk(clk),
      .reset(reset),
      .valid(drdy_in),
      .op_in(operation_in),
      .out_free(out_free),
      .occ(occ),
      .take(take),
      .emit(emit),
      .emit_op(emit_op),
      .emit_step(emit_step)
   );
   // barriers may only enter while the accumulator is empty, keeping op order
   always_comb begin
      out_free = !drdy || ack_in;
      ack = !reset && (take || (!occ && out_free));
      load = emit || (drdy_in && ack && !take);
      dp_ce = drdy && ack_in && (operation[OP_INCDP] || operation[OP_DECDP]);
      dp_down = operation[OP_DECDP];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         drdy <= 1'b0;
         operation <= '0;
         step <= '0;
      end else if (load) begin
         drdy <= 1'b1;
         operation <= emit ? emit_op : operation_in;
         step <= emit ? emit_step : STEP_W'(1);
      end else if (ack_in) begin
         drdy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stage_modify_fold.sv
// tb_stage_modify_fold: cycle table, directed corner cases and folded-stream scoreboard
module tb_stage_modify_fold;
   logic clk = 0, reset = 1, cur = 0, mon_en = 0;
   logic drdy_in[2], ack_in[2], ack[2], drdy[2], dp_ce[2], dp_down[2];
   logic [7:0] op_in[2], op_o[2];
   logic [7:0] step0;
   logic [1:0] step1;
   logic [7:0] pool[8];
   int vectors = 0, miscompares = 0;
   typedef struct {logic [7:0] op; int step;} exp_t;
   exp_t eq[$];
   typedef struct {int din, op, ain, ack, drdy, eop, est, edp;} vec_t;
   vec_t tbl[30];

   stage_modify_fold #(.FOLD(1), .STEP_W(8)) u_big (
      .clk(clk), .reset(reset), .operation_in(op_in[0]), .drdy_in(drdy_in[0]), .ack(ack[0]),
      .operation(op_o[0]), .drdy(drdy[0]), .ack_in(ack_in[0]), .step(step0),
      .dp_ce(dp_ce[0]), .dp_down(dp_down[0]));
   stage_modify_fold #(.FOLD(1), .STEP_W(2)) u_small (
      .clk(clk), .reset(reset), .operation_in(op_in[1]), .drdy_in(drdy_in[1]), .ack(ack[1]),
      .operation(op_o[1]), .drdy(drdy[1]), .ack_in(ack_in[1]), .step(step1),
      .dp_ce(dp_ce[1]), .dp_down(dp_down[1]));

   always #5 clk = ~clk;

   logic m_drdy, m_ack_in, m_dp_ce, m_dp_down;
   logic [7:0] m_op, m_step;
   assign m_drdy = drdy[cur];
   assign m_ack_in = ack_in[cur];
   assign m_dp_ce = dp_ce[cur];
   assign m_dp_down = dp_down[cur];
   assign m_op = op_o[cur];
   assign m_step = cur ? {6'b0, step1} : step0;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (m_drdy && m_ack_in) begin
            if (eq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_out actual=%0h/%0d required=none", m_op, m_step);
            end else begin
               exp_t e;
               e = eq.pop_front();
               chk("out_op", int'(m_op), int'(e.op));
               chk("out_step", int'(m_step), e.step);
               chk("out_dp_ce", int'(m_dp_ce), int'(e.op[2] | e.op[3]));
               chk("out_dp_down", int'(m_dp_down), int'(e.op[3]));
            end
         end else chk("dp_ce_idle", int'(m_dp_ce), 0);
      end
   end

   task automatic send(input logic [7:0] op, input int ackp);
      int n = 0;
      logic a;
      drdy_in[cur] = 1;
      op_in[cur] = op;
      do begin
         ack_in[cur] = int'($urandom_range(0, 99)) < ackp;
         @(negedge clk);
         a = ack[cur];
         @(posedge clk);
         #1;
         n++;
      end while (!a && n < 200);
      if (!a) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout op=%0h actual_ack=0 required=1", op);
      end
   endtask

   task automatic idle(input int n);
      drdy_in[cur] = 0;
      ack_in[cur] = 1;
      op_in[cur] = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void close_run(input int c, input int s);
      if (c != 0 && s != 0)
         eq.push_back('{c == 1 ? (s > 0 ? 8'h04 : 8'h08) : (s > 0 ? 8'h01 : 8'h02), s < 0 ? -s : s});
   endfunction

   // expected output: fold each contiguous same-class run, split where |sum| would exceed the limit
   task automatic burst(input int len);
      logic [7:0] ops[16];
      int c = 0, s = 0, k, d, mx;
      mx = cur ? 3 : 255;
      for (int i = 0; i < len; i++) begin
         if (i > 0 && $urandom_range(0, 99) < 50) ops[i] = ops[i-1];
         else if ($urandom_range(0, 99) < 75) ops[i] = pool[$urandom_range(0, 3)];
         else ops[i] = pool[$urandom_range(4, 7)];
      end
      for (int i = 0; i < len; i++) begin
         k = (ops[i][2] | ops[i][3]) ? 1 : (ops[i][0] | ops[i][1]) ? 2 : 0;
         d = (ops[i][0] | ops[i][2]) ? 1 : -1;
         if (k != 0 && k == c && s + d <= mx && s + d >= -mx) s += d;
         else begin
            close_run(c, s);
            if (k != 0) begin
               c = k;
               s = d;
            end else begin
               eq.push_back('{ops[i], 1});
               c = 0;
            end
         end
      end
      close_run(c, s);
      for (int i = 0; i < len; i++) send(ops[i], 60);
      idle(2);
   endtask

   initial begin
      pool = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      tbl[0]  = '{1, 'h04, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 'h04, 1, 1, 0, 0, 0, 0};
      tbl[2]  = '{1, 'h04, 1, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 'h04, 1, 1, 0, 0, 0, 0};
      tbl[4]  = '{0, 'h00, 1, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 'h00, 1, 1, 1, 'h04, 4, 1};
      tbl[6]  = '{0, 'h00, 1, 1, 0, 0, 0, 0};
      tbl[7]  = '{1, 'h01, 1, 1, 0, 0, 0, 0};
      tbl[8]  = '{1, 'h01, 1, 1, 0, 0, 0, 0};
      tbl[9]  = '{1, 'h01, 1, 1, 0, 0, 0, 0};
      tbl[10] = '{1, 'h08, 1, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 'h08, 1, 1, 1, 'h01, 3, 0};
      tbl[12] = '{0, 'h00, 1, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 'h00, 1, 1, 1, 'h08, 1, 1};
      tbl[14] = '{0, 'h00, 1, 1, 0, 0, 0, 0};
      tbl[15] = '{1, 'h04, 1, 1, 0, 0, 0, 0};
      tbl[16] = '{1, 'h08, 1, 1, 0, 0, 0, 0};
      tbl[17] = '{1, 'h40, 1, 0, 0, 0, 0, 0};
      tbl[18] = '{1, 'h40, 1, 1, 0, 0, 0, 0};
      tbl[19] = '{0, 'h00, 1, 1, 1, 'h40, 1, 0};
      tbl[20] = '{0, 'h00, 1, 1, 0, 0, 0, 0};
      tbl[21] = '{1, 'h10, 0, 1, 0, 0, 0, 0};
      tbl[22] = '{1, 'h04, 0, 1, 1, 'h10, 1, 0};
      tbl[23] = '{1, 'h04, 0, 1, 1, 'h10, 1, 0};
      tbl[24] = '{1, 'h40, 0, 0, 1, 'h10, 1, 0};
      tbl[25] = '{1, 'h40, 0, 0, 1, 'h10, 1, 0};
      tbl[26] = '{1, 'h40, 1, 0, 1, 'h10, 1, 0};
      tbl[27] = '{1, 'h40, 1, 1, 1, 'h04, 2, 1};
      tbl[28] = '{0, 'h00, 1, 1, 1, 'h40, 1, 0};
      tbl[29] = '{0, 'h00, 1, 1, 0, 0, 0, 0};
      for (int i = 0; i < 2; i++) begin
         drdy_in[i] = 1;
         op_in[i] = 8'h04;
         ack_in[i] = 1;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_ack%0d", i), int'(ack[i]), 0);
         chk($sformatf("reset_drdy%0d", i), int'(drdy[i]), 0);
         chk($sformatf("reset_op%0d", i), int'(op_o[i]), 0);
         chk($sformatf("reset_dp_down%0d", i), int'(dp_down[i]), 0);
      end
      chk("reset_step0", int'(step0), 0);
      chk("reset_step1", int'(step1), 0);
      @(posedge clk);
      #1;
      reset = 0;
      drdy_in[1] = 0;
      for (int i = 0; i < 30; i++) begin
         drdy_in[0] = tbl[i].din[0];
         op_in[0] = tbl[i].op[7:0];
         ack_in[0] = tbl[i].ain[0];
         @(negedge clk);
         chk($sformatf("row%0d_ack", i), int'(ack[0]), tbl[i].ack);
         chk($sformatf("row%0d_drdy", i), int'(drdy[0]), tbl[i].drdy);
         chk($sformatf("row%0d_dp_ce", i), int'(dp_ce[0]), tbl[i].edp);
         if (tbl[i].drdy != 0) begin
            chk($sformatf("row%0d_op", i), int'(op_o[0]), tbl[i].eop);
            chk($sformatf("row%0d_step", i), int'(step0), tbl[i].est);
            chk($sformatf("row%0d_dp_down", i), int'(dp_down[0]), tbl[i].eop == 'h08 ? 1 : 0);
         end
         @(posedge clk);
         #1;
      end
      idle(2);
      mon_en = 1;
      send(8'h04, 100);
      send(8'h04, 100);
      reset = 1;
      idle(1);
      reset = 0;
      idle(3);
      eq.push_back('{8'h08, 1});
      send(8'h08, 100);
      idle(4);
      repeat (40) burst($urandom_range(1, 16));
      idle(4);
      chk("big_queue_empty", eq.size(), 0);
      cur = 1;
      eq.push_back('{8'h02, 3});
      eq.push_back('{8'h02, 3});
      eq.push_back('{8'h02, 1});
      repeat (7) send(8'h02, 100);
      idle(4);
      chk("small_limit_queue_empty", eq.size(), 0);
      repeat (40) burst($urandom_range(1, 16));
      idle(4);
      chk("small_queue_empty", eq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
